// File: rtl/shutdown_pkg.sv
// Shared types and constants for the power-down sequencer: FSM states,
// seven-segment digit codes and tube-enable patterns.
package shutdown_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ON        = 2'd1,
        S_COUNTDOWN = 2'd2,
        S_BLINK     = 2'd3
    } state_e;

    // Active-high segments {g..a}; entry 9 sits in the MSB slot.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [7:0] TUBES_ON  = 8'h00;
    localparam logic [7:0] TUBES_OFF = 8'hFF;

    function automatic logic [6:0] seg(input logic [3:0] d);
        return (d > 4'd9) ? 7'h00 : SEG_TABLE[d];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Display-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/shutdown_mode.sv
// Power-down sequencer: watches the main switch while running, then shows a
// digit countdown and a blink on all tubes before returning to off.
module shutdown_mode
    import shutdown_pkg::*;
#(
    parameter int TICK_DIV   = 25_000_000,
    parameter int COUNT_FROM = 3,
    parameter int BLINKS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       openit,
    input  logic       stay,
    output logic [6:0] number,
    output logic [7:0] tube,
    output logic       closing,
    output logic       off
);

    localparam int MAXC = (COUNT_FROM > BLINKS) ? COUNT_FROM : BLINKS;
    localparam int TW   = $clog2(2 * MAXC + 1);
    localparam logic [TW-1:0] BL_LAST = TW'(2 * BLINKS - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic [3:0]    digit_q, digit_d;
    logic          tick;
    logic          clr;

    // Prescaler restarts on every state change so each state's first tick
    // lands TICK_DIV cycles after entry.
    assign clr = (state_d != state_q);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        ticks_d = ticks_q;
        digit_d = digit_q;
        case (state_q)
            S_IDLE: begin
                if (openit && stay) state_d = S_ON;
            end
            S_ON: begin
                if (!openit) begin
                    state_d = S_COUNTDOWN;
                    digit_d = 4'(COUNT_FROM);
                end
            end
            S_COUNTDOWN: begin
                // Abort outranks the final tick.
                if (openit) begin
                    state_d = S_ON;
                end else if (tick) begin
                    ticks_d = ticks_q + 1'b1;
                    if (ticks_q[0]) begin
                        if (digit_q == 4'd1) state_d = S_BLINK;
                        else                 digit_d = digit_q - 4'd1;
                    end
                end
            end
            S_BLINK: begin
                if (tick) begin
                    ticks_d = ticks_q + 1'b1;
                    if (ticks_q == BL_LAST) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) ticks_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ticks_q <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            ticks_q <= ticks_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        number  = 7'h00;
        tube    = TUBES_OFF;
        closing = 1'b0;
        off     = 1'b0;
        case (state_q)
            S_IDLE: off = 1'b1;
            S_ON:   ;
            S_COUNTDOWN: begin
                closing = 1'b1;
                tube    = TUBES_ON;
                number  = seg(digit_q);
            end
            S_BLINK: begin
                closing = 1'b1;
                number  = seg(4'd0);
                tube    = ticks_q[0] ? TUBES_OFF : TUBES_ON;
            end
            default: off = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_shutdown_mode.sv
// Directed bench for shutdown_mode with TICK_DIV=4, COUNT_FROM=3, BLINKS=2.
module tb_shutdown_mode;

    logic       clk = 1'b0;
    logic       rst;
    logic       openit;
    logic       stay;
    logic [6:0] number;
    logic [7:0] tube;
    logic       closing;
    logic       off;

    int checks   = 0;
    int failures = 0;

    shutdown_mode #(.TICK_DIV(4), .COUNT_FROM(3), .BLINKS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .openit  (openit),
        .stay    (stay),
        .number  (number),
        .tube    (tube),
        .closing (closing),
        .off     (off)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_outs(input string tag, input logic off_e, input logic cl_e,
                            input logic [7:0] tube_e, input logic [6:0] num_e);
        check({tag, ".off"},     32'(off),     32'(off_e));
        check({tag, ".closing"}, 32'(closing), 32'(cl_e));
        check({tag, ".tube"},    32'(tube),    32'(tube_e));
        check({tag, ".number"},  32'(number),  32'(num_e));
    endtask

    // Expected outputs k cycles after entering COUNTDOWN (k = 1..41).
    task automatic chk_seq(input string tag, input int k);
        if (k <= 8)       chk_outs(tag, 1'b0, 1'b1, 8'h00, 7'h4F);
        else if (k <= 16) chk_outs(tag, 1'b0, 1'b1, 8'h00, 7'h5B);
        else if (k <= 24) chk_outs(tag, 1'b0, 1'b1, 8'h00, 7'h06);
        else if (k <= 40) chk_outs(tag, 1'b0, 1'b1, (((k - 25) / 4) % 2 == 1) ? 8'hFF : 8'h00, 7'h3F);
        else              chk_outs(tag, 1'b1, 1'b0, 8'hFF, 7'h00);
    endtask

    initial begin
        rst = 1'b1; openit = 1'b1; stay = 1'b1;
        repeat (2) @(negedge clk);
        chk_outs("reset", 1'b1, 1'b0, 8'hFF, 7'h00);

        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_outs("on_after_rst", 1'b0, 1'b0, 8'hFF, 7'h00);

        // Full sequence.
        @(posedge clk); #1 openit = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            chk_seq($sformatf("seq%0d", k), k);
        end

        // IDLE with stay low ignores openit; stay rising enters ON one cycle later.
        @(posedge clk); #1 stay = 1'b0; openit = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outs("idle_nostay", 1'b1, 1'b0, 8'hFF, 7'h00);
        stay = 1'b1;
        #1 chk_outs("idle_stay_pre", 1'b1, 1'b0, 8'hFF, 7'h00);
        @(posedge clk); @(negedge clk);
        chk_outs("stay_to_on", 1'b0, 1'b0, 8'hFF, 7'h00);

        // Abort during digit 2, then restart from digit 3.
        @(posedge clk); #1 openit = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1 || k == 10) chk_seq($sformatf("abrt%0d", k), k);
        end
        openit = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_outs("abort_on", 1'b0, 1'b0, 8'hFF, 7'h00);
        openit = 1'b0;
        @(posedge clk);
        // Toggle openit throughout BLINK; it must have no effect.
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k == 1 || k == 8 || k == 9 || k >= 24) chk_seq($sformatf("rst%0d", k), k);
            openit = (k >= 25 && k < 40) ? k[0] : 1'b0;
        end

        // Reset mid-COUNTDOWN.
        @(posedge clk); #1 openit = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_outs("pre_cd_on", 1'b0, 1'b0, 8'hFF, 7'h00);
        openit = 1'b0;
        @(posedge clk);
        repeat (5) @(negedge clk);
        chk_seq("pre_rst", 5);
        #2 rst = 1'b1;
        #1 chk_outs("async_rst", 1'b1, 1'b0, 8'hFF, 7'h00);
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk_outs("post_rst_idle", 1'b1, 1'b0, 8'hFF, 7'h00);
        openit = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_outs("post_rst_on", 1'b0, 1'b0, 8'hFF, 7'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shutdown_mode.md
# shutdown_mode

Power-down sequencer for the bathroom controller, the counterpart of the power-up standby sequence. While the system is running it watches the main switch. When the switch opens, it runs a visible shutdown sequence on the eight seven-segment tubes: a digit countdown, then a blink. It then returns the controller to the off state. Re-closing the switch during the countdown aborts the shutdown.

## Interface
Parameters:
- TICK_DIV, 25_000_000: clk cycles per display tick (2 Hz at 50 MHz); must be ≥ 2.
- COUNT_FROM, 3: first countdown digit, 1..9.
- BLINKS, 4: number of on/off blink pairs after the countdown, ≥ 1.

Ports:
- clk  in  1  system clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- openit  in  1  main power switch; 1 = on. Already synchronised.
- stay  in  1  1 = power-up standby sequence finished.
- number  out  7  active-high segments {g..a} applied to all enabled tubes.
- tube  out  8  active-low tube enables; bit 7 is the leftmost tube.
- closing  out  1  1 while in COUNTDOWN or BLINK.
- off  out  1  1 while in IDLE.

## Operation
- States: IDLE, ON, COUNTDOWN, BLINK.
- Outputs are Moore-decoded from registered state and counters.
- IDLE: off=1, tube=8'hFF, number=7'h00.
  - Go to ON when openit=1 and stay=1.
- ON: off=0, closing=0, tube=8'hFF, number=7'h00. The display belongs to other blocks.
  - Go to COUNTDOWN when openit=0.
- COUNTDOWN: tube=8'h00; number=seg(digit).
  - digit is loaded with COUNT_FROM on entry.
  - digit decrements every 2 ticks (1 s per digit).
  - After digit 1 has been shown for 2 ticks, go to BLINK.
  - If openit=1 in any cycle, go to ON immediately; digit and tick counter are discarded.
- BLINK: number=seg(0).
  - tube alternates 8'h00 / 8'hFF, starting at 8'h00 and toggling every tick.
  - After 2·BLINKS ticks, go to IDLE.
  - Not abortable: openit is ignored.
- Segment codes (active-high, bit0=a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and asserts tick for one cycle when the count equals TICK_DIV-1.
  - Cleared to 0 on every state change.
  - The first tick in a state therefore occurs TICK_DIV cycles after entry.
- Widths: prescaler is $clog2(TICK_DIV) bits; the tick counter within a state is wide enough for 2·max(COUNT_FROM, BLINKS).

## Timing
- Reset (async assert, sync release): state=IDLE, all counters 0, off=1, closing=0, tube=8'hFF, number=7'h00.
- Transition latency: one clk. A condition sampled at edge N gives new state and outputs after edge N.
- COUNTDOWN lasts exactly 2·COUNT_FROM·TICK_DIV cycles; BLINK lasts exactly 2·BLINKS·TICK_DIV cycles.
- Simultaneous events:
  - In COUNTDOWN, openit=1 in the same cycle as the final tick goes to ON; abort wins.
  - In IDLE, openit=1 with stay=0 stays in IDLE.
- Reset mid-sequence goes to IDLE immediately; no partial blink completes.

## Structure
- Package shutdown_pkg holds:
  - the state enum;
  - the 10-entry segment constant table;
  - TUBES_ON=8'h00 and TUBES_OFF=8'hFF.
- One sub-module, tick_gen:
  - parameterised by TICK_DIV;
  - ports clk, rst, clr, tick;
  - used so the prescaler can be tested alone.
- The FSM, digit counter and blink counter live in shutdown_mode.

## Test plan
Sim parameters: TICK_DIV=4, COUNT_FROM=3, BLINKS=2.
- Reset with openit=1 and stay=1 → IDLE outputs during reset; ON one cycle after release; off=0.
- ON, drop openit → closing=1, tube=00.
  - number=4F for 8 cycles, then 5B for 8, then 06 for 8.
  - Then BLINK: tube 00/FF/00/FF, 4 cycles each, number=3F.
  - Then off=1 at cycle 41 after entry.
- Re-raise openit during digit 2 → ON the next cycle, tube=FF.
  - A later drop of openit restarts the countdown at digit 3.
- Toggle openit during BLINK → no effect; IDLE reached on schedule.
- Assert rst mid-COUNTDOWN → IDLE outputs asynchronously; stay low thereafter until openit=1 and stay=1.
- openit=1 with stay=0 in IDLE → remains IDLE; stay rising → ON the next cycle.
